// File: rtl/jk_seq_driver_if.sv
// Bundle of signals between the JK sequence driver and the logic around it.
// The master side is the driver itself; the slave side supplies start/pattern
// and the q/qbar coming back from the JK flop under test.
interface jk_seq_driver_if #(
  parameter int NUM_STEPS = 4
);
  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                   start;
  logic [2*NUM_STEPS-1:0] pattern;
  logic                   q_in;
  logic                   qbar_in;
  logic [1:0]             jk;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       step_idx;
  logic                   err;
  logic [7:0]             err_count;

  modport master (
    input  start, pattern, q_in, qbar_in,
    output jk, busy, done, step_idx, err, err_count
  );

  modport slave (
    output start, pattern, q_in, qbar_in,
    input  jk, busy, done, step_idx, err, err_count
  );
endinterface

// File: rtl/jk_seq_driver.sv
// Stimulus-and-check engine for a JK flip-flop. Replays a latched list of
// {J,K} commands, each held for HOLD_CYCLES clocks, while a reference JK
// model runs in lock-step and any q/qbar disagreement is counted.
module jk_seq_driver #(
  parameter int HOLD_CYCLES = 5,
  parameter int NUM_STEPS   = 4
) (
  input  logic            clk,
  input  logic            rst,
  jk_seq_driver_if.master bus
);

  localparam int IDX_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(NUM_STEPS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [2*NUM_STEPS-1:0] pat_q, pat_d;
  logic [1:0]             jk_q, jk_d;
  logic [IDX_W-1:0]       step_q, step_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   exp_q, exp_d;
  logic                   err_q, err_d;
  logic [7:0]             err_count_q, err_count_d;

  logic                   mismatch;
  logic [IDX_W-1:0]       step_next;

  // Reference JK behaviour: 00 hold, 01 reset, 10 set, 11 toggle.
  function automatic logic jk_model(input logic q, input logic [1:0] cmd);
    case (cmd)
      2'b01:   jk_model = 1'b0;
      2'b10:   jk_model = 1'b1;
      2'b11:   jk_model = ~q;
      default: jk_model = q;
    endcase
  endfunction

  // Pick command number idx out of the latched pattern.
  function automatic logic [1:0] cmd_at(input logic [2*NUM_STEPS-1:0] pat,
                                        input logic [IDX_W-1:0] idx);
    cmd_at = pat[2*int'(idx) +: 2];
  endfunction

  // Flop disagrees with the model, or its two outputs are not complementary.
  assign mismatch  = (bus.q_in != exp_q) || (bus.qbar_in == bus.q_in);
  assign step_next = step_q + IDX_W'(1);

  // Next-state logic for the sequencer FSM, the reference model and the error counters.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    jk_d        = jk_q;
    step_d      = step_q;
    hold_d      = hold_q;
    exp_d       = exp_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          pat_d       = bus.pattern;
          jk_d        = 2'b01;
          err_d       = 1'b0;
          err_count_d = 8'd0;
          step_d      = '0;
          state_d     = ST_INIT;
        end
      end

      ST_INIT: begin
        // The flop captures 01 at this edge, so its q is known to be 0.
        exp_d   = 1'b0;
        jk_d    = cmd_at(pat_q, '0);
        hold_d  = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (mismatch) begin
          err_d = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
        exp_d = jk_model(exp_q, jk_q);
        if (hold_q < LAST_HOLD) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (step_q < LAST_STEP) begin
          step_d = step_next;
          jk_d   = cmd_at(pat_q, step_next);
          hold_d = '0;
        end else begin
          jk_d    = 2'b00;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; a reset mid-run abandons the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      jk_q        <= 2'b00;
      step_q      <= '0;
      hold_q      <= '0;
      exp_q       <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      jk_q        <= jk_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.jk        = jk_q;
  assign bus.busy      = (state_q == ST_INIT) || (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.step_idx  = step_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench for jk_seq_driver: a behavioural JK flop with selectable
// faults closes the loop, a table of whole runs checks final error status,
// and hand-written sequences cover timing, reset, restart and saturation.
module tb_jk_seq_driver;

  localparam int HOLD  = 5;
  localparam int STEPS = 4;
  localparam int RUN_LEN = HOLD * STEPS;

  logic clk;
  logic rst;
  int   fault_mode;
  logic flop_q;
  int   total;
  int   bad;

  jk_seq_driver_if #(.NUM_STEPS(STEPS)) dut_if ();
  jk_seq_driver_if #(.NUM_STEPS(STEPS)) sat_if ();

  jk_seq_driver #(.HOLD_CYCLES(HOLD), .NUM_STEPS(STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  jk_seq_driver #(.HOLD_CYCLES(100), .NUM_STEPS(STEPS)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_if)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural JK flop driven by the main driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      flop_q <= 1'b0;
    end else begin
      case (dut_if.jk)
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end

  // Fault selection: 0 good flop, 1 q stuck at 0, 2 qbar shorted to q.
  assign dut_if.q_in    = (fault_mode == 1) ? 1'b0 : flop_q;
  assign dut_if.qbar_in = (fault_mode == 1) ? 1'b1 :
                          (fault_mode == 2) ? dut_if.q_in : ~flop_q;
  assign sat_if.q_in    = 1'b0;
  assign sat_if.qbar_in = 1'b1;

  typedef struct {
    logic [7:0] pat;
    int         fault;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start for one clock; returns at the first sample point after the start edge.
  task automatic applyStimulus(input logic [7:0] pat, input int fault);
    @(negedge clk);
    fault_mode     = fault;
    dut_if.pattern = pat;
    dut_if.start   = 1'b1;
    @(negedge clk);
    dut_if.start   = 1'b0;
  endtask

  task automatic waitDone(input string name, input int limit);
    int n;
    n = 0;
    while (!dut_if.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, dut_if.done}, 32'd1);
  endtask

  // Cycle-by-cycle check of jk/step_idx/done from the INIT cycle through done.
  // A start with another pattern is injected at cycle inject_at (negative = never).
  task automatic runSequence(input logic [7:0] pat, input int inject_at,
                             input logic [7:0] inject_pat);
    logic [1:0] exp_jk;
    int         exp_step;
    for (int c = 0; c <= RUN_LEN + 1; c++) begin
      if (c == 0) begin
        exp_jk   = 2'b01;
        exp_step = 0;
      end else if (c <= RUN_LEN) begin
        exp_step = (c - 1) / HOLD;
        exp_jk   = pat[2*exp_step +: 2];
      end else begin
        exp_jk   = 2'b00;
        exp_step = STEPS - 1;
      end
      checkOutput($sformatf("jk[%0d]", c), {30'd0, dut_if.jk}, {30'd0, exp_jk});
      checkOutput($sformatf("step[%0d]", c), {30'd0, dut_if.step_idx}, exp_step);
      checkOutput($sformatf("done[%0d]", c), {31'd0, dut_if.done},
                  (c == RUN_LEN + 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("busy[%0d]", c), {31'd0, dut_if.busy},
                  (c == RUN_LEN + 1) ? 32'd0 : 32'd1);
      dut_if.start = (c == inject_at);
      if (c == inject_at) dut_if.pattern = inject_pat;
      @(negedge clk);
    end
    dut_if.start = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    fault_mode     = 0;
    dut_if.start   = 1'b0;
    dut_if.pattern = 8'h00;
    sat_if.start   = 1'b0;
    sat_if.pattern = 8'h00;

    vecs[0] = '{pat: 8'b11_10_01_00, fault: 0, exp_err: 1'b0, exp_cnt: 8'd0};
    vecs[1] = '{pat: 8'hAA,          fault: 1, exp_err: 1'b1, exp_cnt: 8'd19};
    vecs[2] = '{pat: 8'hE4,          fault: 2, exp_err: 1'b1, exp_cnt: 8'd20};
    vecs[3] = '{pat: 8'h55,          fault: 1, exp_err: 1'b0, exp_cnt: 8'd0};
    vecs[4] = '{pat: 8'hFF,          fault: 0, exp_err: 1'b0, exp_cnt: 8'd0};
    vecs[5] = '{pat: 8'hFF,          fault: 1, exp_err: 1'b1, exp_cnt: 8'd10};

    doReset();
    checkOutput("reset_jk", {30'd0, dut_if.jk}, 32'd0);
    checkOutput("reset_busy", {31'd0, dut_if.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, dut_if.done}, 32'd0);
    checkOutput("reset_err", {31'd0, dut_if.err}, 32'd0);

    // Whole-run vectors: final status after done.
    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(vecs[i].pat, vecs[i].fault);
      waitDone($sformatf("vec%0d_done_timeout", i), RUN_LEN + 10);
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, dut_if.busy}, 32'd0);
      checkOutput($sformatf("vec%0d_jk", i), {30'd0, dut_if.jk}, 32'd0);
      checkOutput($sformatf("vec%0d_step", i), {30'd0, dut_if.step_idx}, STEPS - 1);
      checkOutput($sformatf("vec%0d_err", i), {31'd0, dut_if.err}, {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_cnt", i), {24'd0, dut_if.err_count}, {24'd0, vecs[i].exp_cnt});
    end

    // Exact jk timing with a good flop.
    doReset();
    applyStimulus(8'b11_10_01_00, 0);
    runSequence(8'b11_10_01_00, -1, 8'h00);
    checkOutput("seq_err", {31'd0, dut_if.err}, 32'd0);

    // Start during RUN with another pattern is ignored.
    doReset();
    applyStimulus(8'b10_01_11_10, 0);
    runSequence(8'b10_01_11_10, 7, 8'b01_01_01_01);
    checkOutput("ignore_err", {31'd0, dut_if.err}, 32'd0);

    // Mid-run reset with errors pending clears everything.
    doReset();
    applyStimulus(8'hAA, 1);
    repeat (8) @(negedge clk);
    checkOutput("pre_rst_err", {31'd0, dut_if.err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_jk", {30'd0, dut_if.jk}, 32'd0);
    checkOutput("midrst_busy", {31'd0, dut_if.busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, dut_if.done}, 32'd0);
    checkOutput("midrst_err", {31'd0, dut_if.err}, 32'd0);
    checkOutput("midrst_cnt", {24'd0, dut_if.err_count}, 32'd0);
    checkOutput("midrst_step", {30'd0, dut_if.step_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no_resume_busy", {31'd0, dut_if.busy}, 32'd0);

    // Start from DONE clears errors and re-enters INIT.
    applyStimulus(8'hE4, 2);
    waitDone("restart_first_done_timeout", RUN_LEN + 10);
    checkOutput("restart_first_cnt", {24'd0, dut_if.err_count}, 32'd20);
    applyStimulus(8'hE4, 0);
    checkOutput("restart_busy", {31'd0, dut_if.busy}, 32'd1);
    checkOutput("restart_done", {31'd0, dut_if.done}, 32'd0);
    checkOutput("restart_err", {31'd0, dut_if.err}, 32'd0);
    checkOutput("restart_cnt", {24'd0, dut_if.err_count}, 32'd0);
    checkOutput("restart_jk", {30'd0, dut_if.jk}, 32'd1);
    waitDone("restart_second_done_timeout", RUN_LEN + 10);
    checkOutput("restart_second_err", {31'd0, dut_if.err}, 32'd0);

    // Long hold with q stuck at 0: 399 mismatches must saturate at 255.
    @(negedge clk);
    sat_if.pattern = 8'hAA;
    sat_if.start   = 1'b1;
    @(negedge clk);
    sat_if.start   = 1'b0;
    begin
      int n;
      n = 0;
      while (!sat_if.done && n < 600) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("sat_done", {31'd0, sat_if.done}, 32'd1);
    checkOutput("sat_err", {31'd0, sat_if.err}, 32'd1);
    checkOutput("sat_cnt", {24'd0, sat_if.err_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
